// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
// The converter takes the slave side; the value producer/result consumer takes the master side.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_data;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [DIGITS-1:0]     out_blank;
    logic                  out_neg;
    logic                  out_ovf;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_bcd, out_blank, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_bcd, out_blank, out_neg, out_ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with sign, saturation and blank mask.
// Latency: out_valid rises BIN_W+1 clocks after acceptance; one conversion per BIN_W+2 clocks.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, results hold until next DONE.
module bin2bcd_seq #(
    parameter int BIN_W      = 20,
    parameter int DIGITS     = 6,
    parameter int SIGNED     = 0,
    parameter int BLANK_LEAD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    bin2bcd_seq_if.slave io
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   mag_q;
    logic [BCD_W-1:0]   scr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               ovf_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [DIGITS-1:0]  blank_q;
    logic               valid_q;
    logic               out_neg_q;
    logic               out_ovf_q;

    logic [BCD_W-1:0]   adj_d;
    logic [DIGITS-1:0]  blank_d;
    logic [BIN_W-1:0]   mag_in_d;
    logic               neg_in_d;
    logic               zero_run;

    always_comb begin
        neg_in_d = (SIGNED != 0) && io.in_data[BIN_W-1];
        mag_in_d = neg_in_d ? (~io.in_data + BIN_W'(1)) : io.in_data;
    end

    always_comb begin
        adj_d = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] > 4'd4)
                adj_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
    end

    // Walk down from the top digit; a digit blanks while every digit above it is zero.
    always_comb begin
        blank_d  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (scr_q[4*i +: 4] == 4'd0);
            blank_d[i] = zero_run;
        end
        if (BLANK_LEAD == 0 || ovf_q)
            blank_d = '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= '0;
            valid_q   <= 1'b0;
            out_neg_q <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        mag_q   <= mag_in_d;
                        neg_q   <= neg_in_d;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    {scr_q, mag_q} <= {adj_d[BCD_W-2:0], mag_q, 1'b0};
                    ovf_q          <= ovf_q | adj_d[BCD_W-1];
                    cnt_q          <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    bcd_q     <= ovf_q ? {DIGITS{4'h9}} : scr_q;
                    blank_q   <= blank_d;
                    // A zero result is never shown as negative.
                    out_neg_q <= neg_q && (ovf_q || (scr_q != '0));
                    out_ovf_q <= ovf_q;
                    valid_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = valid_q;
    assign io.out_bcd   = bcd_q;
    assign io.out_blank = blank_q;
    assign io.out_neg   = out_neg_q;
    assign io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Drives three converter configurations and compares every result to an arithmetic model.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        va = 1'b0;
    logic [19:0] da = '0;
    logic        vc = 1'b0;
    logic [7:0]  dc = '0;

    int n_chk = 0;
    int n_fail = 0;

    bin2bcd_seq_if #(.BIN_W(20), .DIGITS(6)) if_a ();
    bin2bcd_seq_if #(.BIN_W(20), .DIGITS(6)) if_b ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if_c ();

    assign if_a.in_valid = va;
    assign if_a.in_data  = da;
    assign if_b.in_valid = va;
    assign if_b.in_data  = da;
    assign if_c.in_valid = vc;
    assign if_c.in_data  = dc;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .SIGNED(0), .BLANK_LEAD(1)) u_a (.clk(clk), .rst_n(rst_n), .io(if_a));
    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .SIGNED(0), .BLANK_LEAD(0)) u_b (.clk(clk), .rst_n(rst_n), .io(if_b));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1), .BLANK_LEAD(1)) u_c (.clk(clk), .rst_n(rst_n), .io(if_c));

    logic [2:0]  vld_o;
    logic [2:0]  rdy_o;
    logic [2:0]  neg_o;
    logic [2:0]  ovf_o;
    logic [23:0] bcd_o [3];
    logic [5:0]  blk_o [3];

    assign vld_o    = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
    assign rdy_o    = {if_c.in_ready, if_b.in_ready, if_a.in_ready};
    assign neg_o    = {if_c.out_neg, if_b.out_neg, if_a.out_neg};
    assign ovf_o    = {if_c.out_ovf, if_b.out_ovf, if_a.out_ovf};
    assign bcd_o[0] = if_a.out_bcd;
    assign bcd_o[1] = if_b.out_bcd;
    assign bcd_o[2] = {12'd0, if_c.out_bcd};
    assign blk_o[0] = if_a.out_blank;
    assign blk_o[1] = if_b.out_blank;
    assign blk_o[2] = {3'd0, if_c.out_blank};

    int cfg_w  [3] = '{20, 20, 8};
    int cfg_d  [3] = '{6, 6, 3};
    bit cfg_s  [3] = '{1'b0, 1'b0, 1'b1};
    bit cfg_bl [3] = '{1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Decimal digits by division; a digit is blank when the magnitude is below 10^i.
    task automatic model(input longint unsigned val, input int bw, input int nd, input bit sgn, input bit bl,
                         output logic [23:0] bcd, output logic [5:0] blank, output logic neg, output logic ovf);
        longint unsigned mag = val;
        longint unsigned tmp;
        neg = 1'b0;
        if (sgn && (((val >> (bw - 1)) & 1) == 1)) begin
            mag = (64'd1 << bw) - val;
            neg = 1'b1;
        end
        ovf   = (mag >= pow10(nd));
        bcd   = '0;
        blank = '0;
        if (ovf) begin
            for (int i = 0; i < nd; i++) bcd[4*i +: 4] = 4'd9;
        end else begin
            tmp = mag;
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
            if (bl)
                for (int i = nd - 1; i > 0; i--) if (mag < pow10(i)) blank[i] = 1'b1;
        end
        if (mag == 0) neg = 1'b0;
    endtask

    task automatic check_result(input int k, input longint unsigned data);
        logic [23:0] eb;
        logic [5:0]  ebl;
        logic        en;
        logic        eo;
        model(data, cfg_w[k], cfg_d[k], cfg_s[k], cfg_bl[k], eb, ebl, en, eo);
        check($sformatf("valid[%0d]", k), vld_o[k], 1'b1);
        check($sformatf("bcd[%0d] in=%0h", k, data), bcd_o[k], eb);
        check($sformatf("blank[%0d] in=%0h", k, data), blk_o[k], ebl);
        check($sformatf("neg[%0d] in=%0h", k, data), neg_o[k], en);
        check($sformatf("ovf[%0d] in=%0h", k, data), ovf_o[k], eo);
        check($sformatf("ready_at_valid[%0d]", k), rdy_o[k], 1'b1);
    endtask

    // w = 0 drives the two 20-bit instances together, w = 2 the signed 8-bit one.
    task automatic convert(input int w, input longint unsigned data);
        int cyc;
        @(negedge clk);
        if (w == 2) begin vc = 1'b1; dc = data[7:0]; end
        else        begin va = 1'b1; da = data[19:0]; end
        check("ready_idle", rdy_o[w], 1'b1);
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        vc = 1'b0;
        check("ready_busy", rdy_o[w], 1'b0);
        cyc = 0;
        while (!vld_o[w] && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, cfg_w[w] + 1);
        check_result(w, data);
        if (w == 0) check_result(1, data);
        @(negedge clk);
        check("valid_pulse", vld_o[w], 1'b0);
    endtask

    initial begin
        int cyc;
        int bad_rdy;
        int pulses;
        longint unsigned r;

        repeat (2) @(negedge clk);
        check("rst_ready", rdy_o, 3'b111);
        check("rst_valid", vld_o, 3'b000);
        check("rst_bcd", bcd_o[0], 24'd0);
        check("rst_blank", blk_o[0], 6'd0);
        check("rst_flags", {neg_o, ovf_o}, 6'd0);
        rst_n = 1'b0;

        convert(0, 999999);
        convert(0, 1000000);
        convert(0, 0);
        convert(0, 40);
        convert(0, 20'hFFFFF);
        convert(0, 1);
        convert(2, 8'h80);
        convert(2, 8'hFF);
        convert(2, 8'h00);
        convert(2, 8'h7F);
        convert(2, 8'h9C);

        for (int i = 0; i < 15; i++) begin
            r = longint'($urandom_range(0, 20'hFFFFF));
            convert(0, r);
            r = longint'($urandom_range(0, 255));
            convert(2, r);
        end

        // Busy input must be ignored and in_ready must stay low until the result.
        @(negedge clk);
        va = 1'b1; da = 20'd123456;
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        cyc = 0; bad_rdy = 0;
        while (!vld_o[0] && cyc < 60) begin
            if (cyc == 4) begin va = 1'b1; da = 20'd654321; end
            else          begin va = 1'b0; end
            if (rdy_o[0]) bad_rdy++;
            @(negedge clk);
            cyc++;
        end
        va = 1'b0;
        check("busy_ready_low", bad_rdy, 0);
        check("busy_latency", cyc, 21);
        check_result(0, 123456);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vld_o[0]) pulses++;
        end
        check("busy_no_second", pulses, 0);
        check("busy_bcd_held", bcd_o[0], 24'h123456);

        // Reset mid-conversion aborts without a result.
        @(negedge clk);
        va = 1'b1; da = 20'd777777;
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ready", rdy_o[0], 1'b1);
        check("abort_bcd", bcd_o[0], 24'd0);
        check("abort_flags", {vld_o[0], blk_o[0], neg_o[0], ovf_o[0]}, 9'd0);
        rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (vld_o[0]) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        convert(0, 12);

        // Held in_valid: back-to-back acceptances every BIN_W+2 clocks.
        @(negedge clk);
        vc = 1'b1; dc = 8'd5;
        cyc = 0;
        while (!vld_o[2] && cyc < 60) begin @(negedge clk); cyc++; end
        check("stream_first", vld_o[2], 1'b1);
        cyc = 0;
        @(negedge clk);
        cyc++;
        while (!vld_o[2] && cyc < 60) begin @(negedge clk); cyc++; end
        vc = 1'b0;
        check("stream_period", cyc, 10);
        check_result(2, 5);
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
